// File: rtl/mean_pkg.sv
// Shared definitions for the mean filter family.
// - MODE_BLOCK / MODE_SLIDING : values of the mode input.
// - state_e                   : accumulation FSM states.
// - acc_width()               : accumulator width for a given sample width and window.
// - scale_mean()              : divides an accumulator by 2^log2_n, floor or round-half-up.
package mean_pkg;

  localparam logic MODE_BLOCK   = 1'b0;
  localparam logic MODE_SLIDING = 1'b1;

  typedef enum logic {
    ST_FILL = 1'b0,  // window not yet complete (always the state in block mode)
    ST_FULL = 1'b1   // sliding window primed, one output per input
  } state_e;

  // A sum of 2^log2_n samples of data_w bits needs log2_n extra bits.
  function automatic int acc_width(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

  // Computed at 64 bits so the optional rounding bias can never overflow;
  // callers keep only the low result bits.
  function automatic logic signed [63:0] scale_mean(input logic signed [63:0] acc,
                                                    input int                 log2_n,
                                                    input bit                 round);
    logic signed [63:0] bias;
    bias = round ? (64'sd1 <<< (log2_n - 1)) : 64'sd0;
    return (acc + bias) >>> log2_n;
  endfunction

endpackage

// File: rtl/mean_ring_buf.sv
// Ring of 2^LOG2_N samples holding the current sliding window.
// - clk, rst : clock, asynchronous active-high reset (pointer only)
// - clear    : synchronous pointer reset
// - we       : write wdata at the pointer and advance it (wraps mod N)
// - wdata    : sample to store
// - oldest   : combinational read of the slot about to be overwritten,
//              i.e. the oldest sample once the window is full
module mean_ring_buf
  import mean_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] oldest
);

  localparam int N = 1 << LOG2_N;

  logic [DATA_W-1:0] mem [N];
  logic [LOG2_N-1:0] wr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
    end else if (we) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the FSM and counter
  // decide when its contents are meaningful, and leaving it unreset lets it
  // map onto plain registers or RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign oldest = mem[wr_ptr];

endmodule

// File: rtl/mean_filter_param.sv
// Parametrised mean engine over a window of N = 2^LOG2_N signed samples.
// Block mode emits one mean per window; sliding mode emits a moving
// average for every input once the first window has filled.
// - clk, rst            : clock, asynchronous active-high reset
// - clear               : synchronous flush of window state, re-latches mode
// - mode                : 0 block, 1 sliding (sampled only at reset/clear)
// - s_axis_data_tvalid/s_axis_data_tready, data_in  : sample input stream
// - m_axis_data_tvalid/m_axis_data_tready, sum_out  : result output stream
module mean_filter_param
  import mean_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 11,
  parameter int ROUND  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              mode,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  input  logic [DATA_W-1:0] data_in,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic [DATA_W-1:0] sum_out
);

  localparam int ACC_W = acc_width(DATA_W, LOG2_N);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] oldest_ext;
  logic        [DATA_W-1:0] oldest;
  logic        [DATA_W-1:0] result;
  logic        [LOG2_N-1:0] count;
  state_e                   state;
  logic                     mode_q;
  logic                     accept;
  logic                     last;
  logic                     issue;

  // Single output register: room exists when it is empty or being drained.
  assign s_axis_data_tready = !m_axis_data_tvalid || m_axis_data_tready;
  assign accept             = s_axis_data_tvalid && s_axis_data_tready && !clear;
  assign last               = &count;  // this accept completes the window

  assign sample_ext = ACC_W'($signed(data_in));
  assign oldest_ext = ACC_W'($signed(oldest));

  // NOTE: every combinational output gets a default before any condition,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_sum = acc + sample_ext;
    if (state == ST_FULL) begin
      acc_sum = acc + sample_ext - oldest_ext;
    end
  end

  assign issue  = accept && ((state == ST_FULL) || last);
  assign result = DATA_W'(scale_mean(64'(acc_sum), LOG2_N, ROUND != 0));

  mean_ring_buf #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .we     (accept && (mode_q == MODE_SLIDING)),
    .wdata  (data_in),
    .oldest (oldest)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc                <= '0;
      count              <= '0;
      state              <= ST_FILL;
      mode_q             <= mode;
      m_axis_data_tvalid <= 1'b0;
      sum_out            <= '0;
    end else begin
      // Output register: a new result may replace one consumed this cycle.
      if (issue) begin
        m_axis_data_tvalid <= 1'b1;
        sum_out            <= result;
      end else if (m_axis_data_tready) begin
        m_axis_data_tvalid <= 1'b0;
      end

      // clear wipes the window but leaves any pending result alone.
      if (clear) begin
        acc    <= '0;
        count  <= '0;
        state  <= ST_FILL;
        mode_q <= mode;
      end else if (accept) begin
        case (state)
          ST_FILL: begin
            count <= count + 1'b1;  // wraps to 0 on the Nth sample
            if (last && (mode_q == MODE_BLOCK)) begin
              acc <= '0;
            end else begin
              acc <= acc_sum;
            end
            if (last && (mode_q == MODE_SLIDING)) begin
              state <= ST_FULL;
            end
          end
          ST_FULL: begin
            acc <= acc_sum;
          end
          default: begin
            state <= ST_FILL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mean_filter_param.sv
// Bench for mean_filter_param. Two default-size instances (floor and
// round-half-up) share one block-mode stimulus stream; a small LOG2_N=2
// round-half-up instance exercises sliding mode, clear and backpressure.
// Expected means come from a queue/arithmetic window model and are popped
// by monitors whenever a DUT result is consumed.
module tb_mean_filter_param;

  localparam int DW  = 16;
  localparam int LGB = 11;
  localparam int NB  = 1 << LGB;
  localparam int LGS = 2;
  localparam int NS  = 1 << LGS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Big pair (shared inputs)
  logic          rst_b = 1'b1, clear_b = 1'b0, mode_b = 1'b0;
  logic          s_valid_b = 1'b0, m_ready_b = 1'b1;
  logic [DW-1:0] data_b = '0;
  logic          s_ready_b0, s_ready_b1, m_valid_b0, m_valid_b1;
  logic [DW-1:0] sum_b0, sum_b1;

  // Small instance
  logic          rst_s = 1'b1, clear_s = 1'b0, mode_s = 1'b1;
  logic          s_valid_s = 1'b0, m_ready_s = 1'b1;
  logic [DW-1:0] data_s = '0;
  logic          s_ready_s, m_valid_s;
  logic [DW-1:0] sum_s;

  mean_filter_param #(.DATA_W(DW), .LOG2_N(LGB), .ROUND(0)) u_big0 (
    .clk(clk), .rst(rst_b), .clear(clear_b), .mode(mode_b),
    .s_axis_data_tvalid(s_valid_b), .s_axis_data_tready(s_ready_b0), .data_in(data_b),
    .m_axis_data_tvalid(m_valid_b0), .m_axis_data_tready(m_ready_b), .sum_out(sum_b0));

  mean_filter_param #(.DATA_W(DW), .LOG2_N(LGB), .ROUND(1)) u_big1 (
    .clk(clk), .rst(rst_b), .clear(clear_b), .mode(mode_b),
    .s_axis_data_tvalid(s_valid_b), .s_axis_data_tready(s_ready_b1), .data_in(data_b),
    .m_axis_data_tvalid(m_valid_b1), .m_axis_data_tready(m_ready_b), .sum_out(sum_b1));

  mean_filter_param #(.DATA_W(DW), .LOG2_N(LGS), .ROUND(1)) u_small (
    .clk(clk), .rst(rst_s), .clear(clear_s), .mode(mode_s),
    .s_axis_data_tvalid(s_valid_s), .s_axis_data_tready(s_ready_s), .data_in(data_s),
    .m_axis_data_tvalid(m_valid_s), .m_axis_data_tready(m_ready_s), .sum_out(sum_s));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] mean_ref(input longint s, input int lg, input bit rnd);
    longint v;
    v = s;
    if (rnd) v = v + (longint'(1) << (lg - 1));
    return DW'(v >>> lg);
  endfunction

  logic [DW-1:0] q_b0[$], q_b1[$], q_s[$];

  longint win_sum_b = 0;
  int     win_cnt_b = 0;

  function automatic void model_b(input logic [DW-1:0] d);
    win_sum_b += longint'($signed(d));
    win_cnt_b++;
    if (win_cnt_b == NB) begin
      q_b0.push_back(mean_ref(win_sum_b, LGB, 1'b0));
      q_b1.push_back(mean_ref(win_sum_b, LGB, 1'b1));
      win_sum_b = 0;
      win_cnt_b = 0;
    end
  endfunction

  longint win_s[$];
  bit     sliding_s = 1'b1;

  function automatic void model_s(input logic [DW-1:0] d);
    longint s;
    win_s.push_back(longint'($signed(d)));
    if (sliding_s && win_s.size() > NS) void'(win_s.pop_front());
    if (win_s.size() == NS) begin
      s = 0;
      foreach (win_s[i]) s += win_s[i];
      q_s.push_back(mean_ref(s, LGS, 1'b1));
      if (!sliding_s) win_s.delete();
    end
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst_b && m_valid_b0 && m_ready_b) begin
      if (q_b0.size() == 0) flag("b0_unexpected_output");
      else check("b0_mean", 32'(sum_b0), 32'(q_b0.pop_front()));
    end
    if (!rst_b && m_valid_b1 && m_ready_b) begin
      if (q_b1.size() == 0) flag("b1_unexpected_output");
      else check("b1_mean", 32'(sum_b1), 32'(q_b1.pop_front()));
    end
  end

  logic          prev_v = 1'b0, prev_r = 1'b0;
  logic [DW-1:0] prev_d = '0;
  always @(negedge clk) begin
    if (!rst_s) begin
      if (prev_v && !prev_r) begin
        check("s_hold_valid", 32'(m_valid_s), 32'd1);
        check("s_hold_data", 32'(sum_s), 32'(prev_d));
      end
      if (m_valid_s && !m_ready_s) check("s_tready_blocked", 32'(s_ready_s), 32'd0);
      if (m_valid_s && m_ready_s) begin
        if (q_s.size() == 0) flag("s_unexpected_output");
        else check("s_mean", 32'(sum_s), 32'(q_s.pop_front()));
      end
    end
    prev_v = m_valid_s;
    prev_r = m_ready_s;
    prev_d = sum_s;
  end

  bit rand_ready_s = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready_s) m_ready_s = ($urandom_range(0, 3) != 0);
  end

  // ---------------- drivers (entered/left at posedge+1) ----------------
  task automatic send_b(input logic [DW-1:0] d);
    int budget;
    budget    = 0;
    s_valid_b = 1'b1;
    data_b    = d;
    @(negedge clk);
    while (!s_ready_b0 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (!s_ready_b0) flag("b_input_timeout");
    else model_b(d);
    @(posedge clk);
    #1;
    s_valid_b = 1'b0;
  endtask

  task automatic send_s(input logic [DW-1:0] d, input bit toggle_mode);
    int budget;
    budget    = 0;
    s_valid_s = 1'b1;
    data_s    = d;
    if (toggle_mode) mode_s = 1'($urandom());  // must be ignored between clears
    @(negedge clk);
    while (!s_ready_s && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (!s_ready_s) flag("s_input_timeout");
    else model_s(d);
    @(posedge clk);
    #1;
    s_valid_s = 1'b0;
  endtask

  task automatic idle_s();
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A sample presented during clear must be dropped.
  task automatic clear_small(input logic new_mode);
    clear_s   = 1'b1;
    mode_s    = new_mode;
    s_valid_s = 1'b1;
    data_s    = 16'h7ABC;
    @(posedge clk);
    #1;
    clear_s   = 1'b0;
    s_valid_s = 1'b0;
    win_s.delete();
    sliding_s = new_mode;
  endtask

  task automatic block_window_b(input logic [DW-1:0] d);
    for (int i = 0; i < NB - 1; i++) send_b(d);
    check("b_no_early_valid", 32'(m_valid_b0), 32'd0);
    send_b(d);
    check("b0_latency", 32'(m_valid_b0), 32'd1);
    check("b1_latency", 32'(m_valid_b1), 32'd1);
  endtask

  initial begin
    #50000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] blk_vec [12];
    blk_vec = '{16'h0001, 16'h0000, 16'h0000, 16'h0001,
                16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                16'hFFFD, 16'h0000, 16'h0000, 16'h0000};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_b0_valid", 32'(m_valid_b0), 32'd0);
    check("rst_b0_sum", 32'(sum_b0), 32'd0);
    check("rst_b0_tready", 32'(s_ready_b0), 32'd1);
    check("rst_b1_valid", 32'(m_valid_b1), 32'd0);
    check("rst_s_valid", 32'(m_valid_s), 32'd0);
    check("rst_s_sum", 32'(sum_s), 32'd0);
    check("rst_s_tready", 32'(s_ready_s), 32'd1);
    @(negedge clk);
    rst_b = 1'b0;
    rst_s = 1'b0;
    @(posedge clk);
    #1;

    // Sliding, N=4: no output for the first three, then 10 and 14.
    send_s(16'h0004, 1'b0);
    send_s(16'h0008, 1'b0);
    send_s(16'h000C, 1'b0);
    check("s_no_output_yet", 32'(m_valid_s), 32'd0);
    send_s(16'h0010, 1'b0);
    check("s_first_valid", 32'(m_valid_s), 32'd1);
    check("s_first_mean", 32'(sum_s), 32'h000A);
    send_s(16'h0014, 1'b0);
    check("s_wrap_mean", 32'(sum_s), 32'h000E);

    // Random sliding traffic with backpressure; mode input wiggles are ignored.
    rand_ready_s = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_s(16'($urandom()), 1'b1);
      idle_s();
    end

    // Block mode with rounding boundary windows, then random block traffic.
    clear_small(1'b0);
    foreach (blk_vec[i]) send_s(blk_vec[i], 1'b1);
    for (int i = 0; i < 100; i++) begin
      send_s(16'($urandom()), 1'b1);
      idle_s();
    end

    // Partial block window, then clear into sliding mode: partial sum discarded.
    send_s(16'h7FFF, 1'b0);
    send_s(16'h7FFF, 1'b0);
    clear_small(1'b1);
    for (int i = 0; i < 200; i++) begin
      send_s(16'($urandom()), 1'b1);
      idle_s();
    end
    rand_ready_s = 1'b0;
    @(posedge clk);
    #1;
    m_ready_s = 1'b1;

    // Big block windows at default size.
    block_window_b(16'h4000);
    block_window_b(16'hC000);
    block_window_b(16'h7FFF);
    block_window_b(16'h8000);

    // Mixed extremes: floor gives -1, round-half-up gives 0.
    for (int i = 0; i < NB / 2; i++) send_b(16'h7FFF);
    for (int i = 0; i < NB / 2; i++) send_b(16'h8000);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a window.
    for (int i = 0; i < 1000; i++) send_b(16'h2000);
    rst_b = 1'b1;
    #1;
    check("midrst_b0_valid", 32'(m_valid_b0), 32'd0);
    check("midrst_b0_sum", 32'(sum_b0), 32'd0);
    check("midrst_b0_tready", 32'(s_ready_b0), 32'd1);
    check("midrst_b1_sum", 32'(sum_b1), 32'd0);
    win_sum_b = 0;
    win_cnt_b = 0;
    q_b0.delete();
    q_b1.delete();
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    block_window_b(16'h2000);

    // Drain and confirm every expected result appeared.
    for (int i = 0; i < 100; i++) begin
      if (q_b0.size() == 0 && q_b1.size() == 0 && q_s.size() == 0) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    check("q_b0_drained", 32'(q_b0.size()), 32'd0);
    check("q_b1_drained", 32'(q_b1.size()), 32'd0);
    check("q_s_drained", 32'(q_s.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mean_filter_param.md
Name: mean_filter_param

Overview:
Parametrised Q1.DATA_W-1 mean engine and the successor to the fixed 2048-sample mean block. Window length is 2^LOG2_N and two modes are selectable at runtime:
- Block mode: one decimated mean per window.
- Sliding mode: moving average, one output per input once the window is full.
It sits between an AXI-Stream sample source and downstream DSP, and uses the same s_axis/m_axis handshake naming as the existing mean block.

Parameters:
DATA_W, 16, sample and result width, signed two's complement (Q1.15 at default)
LOG2_N, 11, log2 of window length N (N = 2048 at default); legal range 1..12
ROUND, 0, 0 = floor (arithmetic shift), 1 = round half up

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
clear  in  1  synchronous flush of accumulator, counter and window; result register untouched
mode  in  1  0 = block mean, 1 = sliding mean; latched only at reset/clear
s_axis_data_tvalid  in  1  input sample valid
s_axis_data_tready  out  1  input ready
data_in  in  DATA_W  signed input sample
m_axis_data_tvalid  out  1  result valid
m_axis_data_tready  in  1  downstream ready
sum_out  out  DATA_W  signed mean result

Behaviour:
- Reset values:
  - sum_out = 0, m_axis_data_tvalid = 0, s_axis_data_tready = 1.
  - Accumulator = 0, count = 0, wr_ptr = 0, FSM = FILL.
  - Latched mode = mode input value during reset.
- Input handshake: a sample is accepted when s_axis_data_tvalid && s_axis_data_tready. s_axis_data_tready = !m_axis_data_tvalid || m_axis_data_tready (combinational, single output register, no skid).
- Output handshake: m_axis_data_tvalid and sum_out hold stable until m_axis_data_tready. A new result may load in the same cycle the old one is consumed.
- Accumulator:
  - ACC_W = DATA_W + LOG2_N, signed.
  - Each sample is sign-extended to ACC_W before accumulation; no overflow is possible.
- Result computation:
  - ROUND = 0: result = acc[ACC_W-1:LOG2_N].
  - ROUND = 1: result = (acc + 2^(LOG2_N-1)) >>> LOG2_N, computed in ACC_W+1 bits, low DATA_W bits taken. The result cannot exceed the max code, so no saturation is needed.
- FSM states: FILL, FULL (FULL is reachable in sliding mode only).
  - FILL, block mode:
    - Each accept adds the sample and increments count.
    - On the Nth accept: next-cycle sum_out = mean(acc + sample), m_tvalid = 1, acc ← 0, count ← 0. State stays FILL.
    - Latency: 1 clk from the Nth handshake to m_tvalid.
  - FILL, sliding mode:
    - Each accept writes the sample to ring[wr_ptr], adds it to acc and increments wr_ptr (wraps mod N) and count.
    - On the Nth accept: result is issued as in block mode, then go to FULL.
  - FULL (sliding only):
    - Each accept: acc ← acc + sample − ring[wr_ptr] (oldest sample, read combinationally).
    - ring[wr_ptr] ← sample, wr_ptr++ with wrap.
    - Result is issued 1 clk later. One output per input.
- Ring buffer: N × DATA_W register array, written in sliding mode only, never cleared. Validity is governed by count/FSM.
- clear: acc, count, wr_ptr ← 0; FSM → FILL; mode re-latched. Any sample presented in the clear cycle is dropped. A pending output remains valid.
- Simultaneous events:
  - clear overrides accept.
  - rst overrides everything, asynchronously, including mid-window; the partial window is discarded.
- Mode input changes between clears are ignored.

Decomposition:
- Shared package mean_pkg:
  - MODE_BLOCK / MODE_SLIDING constants.
  - FSM state encoding.
  - Function acc_width(DATA_W, LOG2_N).
  - Rounding helper function.
- Sub-module mean_ring_buf: N × DATA_W ring with write enable, wrap-around write pointer and combinational oldest-sample read.

Test Plan:
1. Block, defaults, 2048 × 0x4000 / 0xC000 / 0x7FFF / 0x8000 -> exactly one output each, sum_out = same value, m_tvalid 1 clk after the 2048th handshake.
2. Block, 1024 × 0x7FFF then 1024 × 0x8000 -> ROUND=0: sum_out = 0xFFFF; ROUND=1: sum_out = 0x0000.
3. Sliding, LOG2_N=2, inputs 0x0004, 0x0008, 0x000C, 0x0010, 0x0014 -> no output for the first 3; then 0x000A, then 0x000E (wrap-around of ring verified).
4. Backpressure: hold m_axis_data_tready = 0 with a result pending -> s_axis_data_tready = 0, sum_out stable; release -> accept resumes with no sample lost or duplicated, checked against a reference model.
5. Assert rst at sample 1000 of a block window -> all outputs at reset values immediately; the next 2048 × 0x2000 give 0x2000.
6. clear mid-window with mode switched 0 → 1 -> the partial sum is discarded; sliding behaviour starts from an empty window.
